// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the hex scanner and its decoder.
// Bit 0 of every pattern is segment a and bit 6 is segment g; patterns are active-high.
package seg7_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg7_t;

    // Hex glyphs 0..F, written as g..a so each literal reads MSB = g.
    localparam seg7_t SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam seg7_t SEG7_BLANK = '0;

endpackage

// File: rtl/hex_display_scanner_if.sv
// Port bundle of hex_display_scanner: datapath side (en/load/value/lz_blank) and board pins.
// With HEX_SCAN_DP_EN defined, it also carries the per-digit decimal points (dp in, seg_dp out).
interface hex_display_scanner_if #(
    parameter int N_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic                    lz_blank;
    seg7_pkg::seg7_t         seg;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_tick;
`ifdef HEX_SCAN_DP_EN
    logic [N_DIGITS-1:0]     dp;
    logic                    seg_dp;

    modport master (
        output en, load, value, lz_blank, dp,
        input  seg, an, frame_tick, seg_dp
    );
    modport slave (
        input  en, load, value, lz_blank, dp,
        output seg, an, frame_tick, seg_dp
    );
`else
    modport master (
        output en, load, value, lz_blank,
        input  seg, an, frame_tick
    );
    modport slave (
        input  en, load, value, lz_blank,
        output seg, an, frame_tick
    );
`endif
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-high seven-segment pattern (bit 0 = a).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      pattern
);

    assign pattern = SEG7_HEX[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed N-digit hex display driver with active-low segment and anode outputs.
// Optional decimal-point support is compiled in with the HEX_SCAN_DP_EN macro.
module hex_display_scanner
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [4*N_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  last_digit;
    logic                  lead_zero;
    logic                  blank;
    logic [3:0]            nibble;
    seg7_t                 pattern;

    assign tick       = bus.en && (cnt == CNT_W'(DIV - 1));
    assign last_digit = (idx == IDX_W'(N_DIGITS - 1));
    assign nibble     = shadow[{idx, 2'b00} +: 4];

    // Leading zero: this nibble and every more significant one are zero.
    assign lead_zero  = ((shadow >> {idx, 2'b00}) == '0);
    assign blank      = bus.lz_blank && lead_zero && (idx != '0);

    seg7_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

`ifdef HEX_SCAN_DP_EN
    logic [N_DIGITS-1:0] dp_shadow;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_shadow  <= '0;
            bus.seg_dp <= 1'b1;
        end else begin
            if (bus.load) begin
                dp_shadow <= bus.dp;
            end
            if (bus.en && !blank) begin
                bus.seg_dp <= ~dp_shadow[idx];
            end else begin
                bus.seg_dp <= 1'b1;
            end
        end
    end
`endif

    // Outputs are registered from the pre-edge idx/shadow, so they trail idx by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow         <= '0;
            cnt            <= '0;
            idx            <= '0;
            bus.seg        <= '1;
            bus.an         <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.value;
            end

            if (tick) begin
                cnt <= '0;
                idx <= last_digit ? '0 : idx + IDX_W'(1);
            end else if (bus.en) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (bus.en) begin
                bus.seg <= blank ? ~SEG7_BLANK : ~pattern;
                bus.an  <= ~(N_DIGITS'(1) << idx);
            end else begin
                bus.seg <= '1;
                bus.an  <= '1;
            end

            bus.frame_tick <= tick && last_digit;
        end
    end

endmodule
